// File: rtl/timer_pkg.sv
// Timer time-base shared types: counting mode, direction
// encodings and default widths.
package timer_pkg;

  typedef enum logic [1:0] {
    EDGE    = 2'b00,
    CENTER1 = 2'b01,
    CENTER2 = 2'b10,
    CENTER3 = 2'b11
  } cms_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 16;
  localparam int RCR_W_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: shadowed divide value and free-running
// divider producing one tick every psc_act+1 running cycles.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_WIDTH = PSC_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 run,
  input  logic                 clr,
  input  logic                 load,
  input  logic [PSC_WIDTH-1:0] psc_i,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] psc_act;
  logic [PSC_WIDTH-1:0] psc_cnt;

  assign tick = run & (psc_cnt == psc_act);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      psc_act <= '0;
      psc_cnt <= '0;
    end else begin
      if (load) psc_act <= psc_i;
      if (clr || tick) psc_cnt <= '0;
      else if (run) psc_cnt <= psc_cnt + PSC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_time_base.sv
// Timer time base: counter, auto-reload shadow, repetition
// counter, update event generation and one-pulse control.
module timer_time_base
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_W_DEF,
  parameter int PSC_WIDTH = PSC_W_DEF,
  parameter int RCR_WIDTH = RCR_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 cen_i,
  input  logic                 dir_i,
  input  logic [1:0]           cms_i,
  input  logic                 opm_i,
  input  logic                 arpe_i,
  input  logic                 udis_i,
  input  logic                 urs_i,
  input  logic                 ug_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic [RCR_WIDTH-1:0] rcr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 uev_o,
  output logic                 uif_o,
  output logic                 opm_stop_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic                 running;
  logic                 tick;
  logic                 cen_q;
  logic                 cen_rise;
  logic                 stopped;
  cms_e                 mode_q;
  cms_e                 cms_in;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] arr_act;
  logic [CNT_WIDTH-1:0] ug_cnt;
  logic                 dir_q;
  logic                 dir_d;
  logic                 ug_dir;
  logic [RCR_WIDTH-1:0] rcr_act;
  logic [RCR_WIDTH-1:0] rep_q;
  logic [RCR_WIDTH-1:0] rep_d;
  logic                 evt;
  logic                 rep_done;
  logic                 ctr_uev;
  logic                 upd;
  logic                 uev_q;
  logic                 uif_q;
  logic                 ops_q;

  assign cms_in   = cms_e'(cms_i);
  assign running  = cen_i & ~stopped;
  assign cen_rise = cen_i & ~cen_q;

  timer_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_psc (
    .clk_i    (clk_i),
    .aresetn_i(aresetn_i),
    .run      (running),
    .clr      (ug_i),
    .load     (upd),
    .psc_i    (psc_i),
    .tick     (tick)
  );

  // Up-compares use >= so a shrunk ARR without preload wraps at once.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = (mode_q == EDGE) ? dir_i : dir_q;
    evt   = 1'b0;
    if (tick) begin
      if (arr_act == '0) begin
        cnt_d = '0;
      end else if (mode_q == EDGE) begin
        if (dir_i == DIR_UP) begin
          if (cnt_q >= arr_act) begin
            cnt_d = '0;
            evt   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (cnt_q == '0) begin
          cnt_d = arr_act;
          evt   = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= arr_act) begin
          cnt_d = arr_act - ONE;
          dir_d = DIR_DOWN;
          evt   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (cnt_q == '0) begin
        cnt_d = ONE;
        dir_d = DIR_UP;
        evt   = 1'b1;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  assign rep_done = evt & (rep_q == '0);
  assign ctr_uev  = rep_done & ~udis_i & ~ug_i;
  assign upd      = ug_i | ctr_uev;

  // Reload takes the post-update repetition value.
  always_comb begin
    rep_d = rep_q;
    if (ug_i) rep_d = rcr_i;
    else if (rep_done) rep_d = ctr_uev ? rcr_i : rcr_act;
    else if (evt) rep_d = rep_q - RCR_WIDTH'(1);
  end

  assign ug_cnt = (cms_in == EDGE && dir_i == DIR_DOWN) ? arr_i : '0;
  assign ug_dir = (cms_in == EDGE) ? dir_i : DIR_UP;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= EDGE;
      rep_q   <= '0;
      stopped <= 1'b0;
      cen_q   <= 1'b0;
      arr_act <= '1;
      rcr_act <= '0;
      uev_q   <= 1'b0;
      uif_q   <= 1'b0;
      ops_q   <= 1'b0;
    end else begin
      cen_q <= cen_i;
      rep_q <= rep_d;
      if (ug_i) begin
        cnt_q  <= ug_cnt;
        dir_q  <= ug_dir;
        mode_q <= cms_in;
      end else begin
        cnt_q <= cnt_d;
        dir_q <= dir_d;
        if (!running) mode_q <= cms_in;
      end
      if (upd || !arpe_i) arr_act <= arr_i;
      if (upd) rcr_act <= rcr_i;
      if (ug_i) stopped <= 1'b0;
      else if (ctr_uev && opm_i) stopped <= 1'b1;
      else if (cen_rise) stopped <= 1'b0;
      uev_q <= upd;
      uif_q <= ctr_uev | (ug_i & ~urs_i);
      ops_q <= ctr_uev & opm_i;
    end
  end

  assign cnt_o      = cnt_q;
  assign dir_o      = dir_q;
  assign uev_o      = uev_q;
  assign uif_o      = uif_q;
  assign opm_stop_o = ops_q;

endmodule

// File: tb/tb_timer_time_base.sv
// Bench for timer_time_base: spec-level model compared every
// cycle, plus directed sequences with literal expectations.
module tb_timer_time_base;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cen, dir, opm, arpe, udis, urs, ug;
  logic [1:0]  cms;
  logic [15:0] psc, arr;
  logic [7:0]  rcr;
  logic [15:0] cnt_o;
  logic        dir_o, uev_o, uif_o, opm_stop_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_cnt, m_pc, m_psc, m_arr, m_rcr, m_rep, m_mode;
  bit m_dir, m_stop, m_cenp, m_uev, m_uif, m_ops;

  int exp2 [13] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
  int exp3 [14] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};
  int dir3 [14] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

  timer_time_base dut (
    .clk_i     (clk),
    .aresetn_i (aresetn),
    .cen_i     (cen),
    .dir_i     (dir),
    .cms_i     (cms),
    .opm_i     (opm),
    .arpe_i    (arpe),
    .udis_i    (udis),
    .urs_i     (urs),
    .ug_i      (ug),
    .psc_i     (psc),
    .arr_i     (arr),
    .rcr_i     (rcr),
    .cnt_o     (cnt_o),
    .dir_o     (dir_o),
    .uev_o     (uev_o),
    .uif_o     (uif_o),
    .opm_stop_o(opm_stop_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_pc = 0; m_psc = 0; m_arr = 65535; m_rcr = 0;
    m_rep = 0; m_mode = 0; m_dir = 0; m_stop = 0; m_cenp = 0;
    m_uev = 0; m_uif = 0; m_ops = 0;
  endtask

  // One clock of the timer as described by its rules.
  task automatic m_step();
    bit run, tick, evt, cuev;
    int top;
    run = cen && !m_stop;
    evt = 0;
    cuev = 0;
    if (ug) begin
      m_mode = int'(cms);
      m_pc = 0;
      m_cnt = (cms == 0 && dir) ? int'(arr) : 0;
      m_dir = (cms == 0) ? dir : 1'b0;
      m_rep = rcr; m_psc = psc; m_arr = arr; m_rcr = rcr;
      m_stop = 0;
      m_uev = 1; m_uif = !urs; m_ops = 0;
    end else begin
      tick = run && (m_pc == m_psc);
      if (run) m_pc = tick ? 0 : m_pc + 1;
      top = m_arr;
      if (m_mode == 0) m_dir = dir;
      if (tick) begin
        if (top == 0) begin
          m_cnt = 0;
        end else if (m_mode == 0 && !dir) begin
          m_cnt = (m_cnt + 1) % (top + 1);
          evt = (m_cnt == 0);
        end else if (m_mode == 0) begin
          evt = (m_cnt == 0);
          m_cnt = evt ? top : m_cnt - 1;
        end else begin
          if (!m_dir && m_cnt == top) begin evt = 1; m_dir = 1; end
          else if (m_dir && m_cnt == 0) begin evt = 1; m_dir = 0; end
          m_cnt += m_dir ? -1 : 1;
        end
      end
      if (evt) begin
        if (m_rep == 0) begin
          cuev = !udis;
          m_rep = cuev ? int'(rcr) : m_rcr;
        end else begin
          m_rep--;
        end
      end
      if (cuev) begin m_psc = psc; m_rcr = rcr; m_arr = arr; end
      if (!arpe) m_arr = arr;
      if (!run) m_mode = int'(cms);
      m_uev = cuev; m_uif = cuev; m_ops = cuev && opm;
      if (cuev && opm) m_stop = 1;
      else if (cen && !m_cenp) m_stop = 0;
    end
    m_cenp = cen;
  endtask

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_cnt", cnt_o, m_cnt);
      chk("model_dir", dir_o, m_dir);
      chk("model_uev", uev_o, m_uev);
      chk("model_uif", uif_o, m_uif);
      chk("model_opm", opm_stop_o, m_ops);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop, apply ug with current settings, then run.
  task automatic restart();
    cen = 0;
    cyc(1);
    ug = 1;
    cyc(1);
    ug = 0;
    cen = 1;
  endtask

  initial begin
    aresetn = 0;
    cen = 0; dir = 0; cms = 0; opm = 0; arpe = 0;
    udis = 0; urs = 0; ug = 0;
    psc = 0; arr = 0; rcr = 0;
    cyc(3);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_uev", uev_o, 0);
    chk("rst_uif", uif_o, 0);
    chk("rst_opm", opm_stop_o, 0);
    aresetn = 1;
    chk_en = 1;
    cyc(2);

    // edge up, psc 0, arr 4
    arr = 4;
    restart();
    for (int i = 0; i < 11; i++) begin
      chk("up_cnt", cnt_o, i % 5);
      chk("up_uev", uev_o, (i % 5) == 0);
      cyc(1);
    end

    // edge down, psc 2, arr 3
    psc = 2; arr = 3; dir = 1;
    restart();
    for (int i = 0; i < 13; i++) begin
      chk("dn_cnt", cnt_o, exp2[i]);
      chk("dn_uev", uev_o, i == 0 || i == 12);
      if (i == 0) chk("dn_dir", dir_o, 1);
      cyc(1);
    end

    // center, arr 3, rcr 1
    psc = 0; dir = 0; cms = 2'b01; rcr = 1;
    restart();
    for (int i = 0; i < 14; i++) begin
      chk("ctr_cnt", cnt_o, exp3[i]);
      chk("ctr_dir", dir_o, dir3[i]);
      chk("ctr_uev", uev_o, i == 0 || i == 7 || i == 13);
      cyc(1);
    end

    // ARR preload on: change mid-period takes effect next period
    cms = 0; rcr = 0; arr = 9; arpe = 1;
    restart();
    cyc(3);
    chk("arpe_mid", cnt_o, 3);
    arr = 5;
    cyc(6);
    chk("arpe_top9", cnt_o, 9);
    cyc(1);
    chk("arpe_wrap9", cnt_o, 0);
    chk("arpe_uev9", uev_o, 1);
    cyc(5);
    chk("arpe_top5", cnt_o, 5);
    cyc(1);
    chk("arpe_wrap5", cnt_o, 0);
    chk("arpe_uev5", uev_o, 1);

    // ARR preload off: new ARR applies at once
    arr = 9;
    restart();
    cyc(3);
    arpe = 0; arr = 5;
    cyc(2);
    chk("nopre_top", cnt_o, 5);
    cyc(1);
    chk("nopre_wrap", cnt_o, 0);
    chk("nopre_uev", uev_o, 1);

    // arr 0: counter holds 0 without events
    arr = 0;
    restart();
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("arr0_cnt", cnt_o, 0);
      chk("arr0_uev", uev_o, 0);
    end

    // one-pulse mode
    opm = 1; arr = 2;
    restart();
    cyc(3);
    chk("opm_cnt", cnt_o, 0);
    chk("opm_uev", uev_o, 1);
    chk("opm_stop", opm_stop_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("opm_hold", cnt_o, 0);
      chk("opm_nouev", uev_o, 0);
      chk("opm_nostop", opm_stop_o, 0);
    end
    cen = 0;
    cyc(1);
    cen = 1;
    cyc(2);
    chk("opm_restart", cnt_o, 1);
    cyc(2);
    chk("opm_stop2", opm_stop_o, 1);
    opm = 0;

    // ug with udis and urs set, mid-count
    arr = 9;
    restart();
    cyc(4);
    chk("ug_pre", cnt_o, 4);
    udis = 1; urs = 1; ug = 1;
    cyc(1);
    ug = 0;
    chk("ug_uev", uev_o, 1);
    chk("ug_uif", uif_o, 0);
    chk("ug_cnt", cnt_o, 0);
    cyc(10);
    chk("udis_wrap", cnt_o, 0);
    chk("udis_nouev", uev_o, 0);

    // asynchronous reset mid-count
    cyc(3);
    #2 aresetn = 0;
    #1;
    chk("arst_cnt", cnt_o, 0);
    chk("arst_dir", dir_o, 0);
    chk("arst_uev", uev_o, 0);
    chk("arst_uif", uif_o, 0);
    chk("arst_opm", opm_stop_o, 0);
    cyc(2);
    aresetn = 1;
    udis = 0; urs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("rel_uev", uev_o, 0);
      chk("rel_uif", uif_o, 0);
    end

    cen = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_time_base.md
TIMER_TIME_BASE -- requirements
Module: timer_time_base

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, counter and auto-reload width (2..32).
REQ-002 SHALL have parameter PSC_WIDTH, default 16, prescaler width.
REQ-003 SHALL have parameter RCR_WIDTH, default 8, repetition counter width.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port aresetn_i, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port cen_i, input, 1, counter enable (level).
REQ-007 SHALL have port dir_i, input, 1, direction in edge mode (0 up, 1 down).
REQ-008 SHALL have port cms_i, input, 2, mode (00 edge-aligned; 01/10/11 center-aligned).
REQ-009 SHALL have ports opm_i, arpe_i, udis_i, urs_i, ug_i, input, 1 each: one-pulse, ARR preload enable, update disable, update request source, software update generate.
REQ-010 SHALL have ports psc_i [PSC_WIDTH], arr_i [CNT_WIDTH] and rcr_i [RCR_WIDTH], input: prescaler, auto-reload and repetition values.
REQ-011 SHALL have ports cnt_o [CNT_WIDTH] and dir_o [1], output: current count and effective direction.
REQ-012 SHALL have ports uev_o, uif_o and opm_stop_o, output, 1 each: update event pulse, update flag pulse, one-pulse stop pulse.

Function
REQ-013 SHALL hold psc_act, arr_act and rcr_act shadow registers; psc_act and rcr_act load only on UEV; arr_act loads on UEV when arpe_i=1, else every cycle from arr_i.
REQ-014 SHALL tick when running and prescaler counter == psc_act; prescaler counter wraps to 0 on tick, otherwise increments; division ratio = psc_act+1.
REQ-015 SHALL define running = cen_i & ~stopped; a held prescaler/counter keeps its value when not running.
REQ-016 Edge up (cms 00, dir_i 0), on tick: cnt==arr_act -> cnt<=0, overflow; else cnt+1.
REQ-017 Edge down (cms 00, dir_i 1), on tick: cnt==0 -> cnt<=arr_act, underflow; else cnt-1.
REQ-018 Center (cms!=00): count 0 up to arr_act, overflow at arr_act, reverse to arr_act-1; count down to 0, underflow at 0, reverse to 1; dir_i ignored; dir_o gives current direction.
REQ-019 SHALL ignore cms_i changes while running; mode SHALL be sampled at UG or while stopped.
REQ-020 With arr_act==0, counter SHALL hold 0 and produce no overflow/underflow.
REQ-021 Each overflow/underflow SHALL decrement rep_cnt; when rep_cnt==0 at the event, SHALL raise UEV and reload rep_cnt from rcr_act (post-load value).
REQ-022 udis_i=1 SHALL suppress counter-driven UEV (no shadow loads, rep_cnt still reloads to rcr_act).
REQ-023 ug_i=1 SHALL force UEV regardless of udis_i: prescaler<=0, cnt<=0 (up/center) or arr_i (down), rep_cnt<=rcr_i, shadows load; center direction resets to up.
REQ-024 ug_i SHALL win over a simultaneous counter event (single UEV).
REQ-025 uev_o SHALL be registered, one cycle high, coincident with the updated cnt_o value.
REQ-026 uif_o SHALL pulse with every uev_o except UG-sourced when urs_i=1.
REQ-027 opm_i=1: a counter-driven UEV SHALL set stopped and pulse opm_stop_o; cnt_o holds the wrapped value.
REQ-028 stopped SHALL clear on a cen_i rising edge or ug_i.

Reset
REQ-029 On aresetn_i low: cnt_o=0, dir_o=0, uev_o=0, uif_o=0, opm_stop_o=0, prescaler=0, rep_cnt=0, stopped=0, psc_act=0, arr_act=all ones, rcr_act=0.
REQ-030 Reset mid-count SHALL abort immediately; no event SHALL be produced on release.

Structure
REQ-031 Shared package timer_pkg SHALL hold the cms enum typedef (EDGE, CENTER1..3), direction constants and default widths.
REQ-032 SHALL contain one sub-module timer_prescaler (psc shadow, counter, tick output); the rest is flat.

Verification
REQ-033 psc_i=0, arr_i=4, cms 00 up, cen 1 -> cnt_o 0,1,2,3,4,0; uev_o high with cnt_o=0, every 5 cycles.
REQ-034 psc_i=2, arr_i=3, down -> each value held 3 cycles; underflow reloads 3; uev_o period 12 cycles.
REQ-035 Center, arr_i=3, rcr_i=1 -> cnt_o 0,1,2,3,2,1,0,1; uev_o on every 2nd turn point; dir_o toggles at 3 and 0.
REQ-036 arpe_i=1, arr_i 9->5 mid-period -> wrap still at 9; next period wraps at 5; arpe_i=0 -> wrap at 5 immediately.
REQ-037 opm_i=1, arr_i=2 -> single period, opm_stop_o pulse, cnt_o holds 0; cen_i 0->1 restarts.
REQ-038 ug_i with udis_i=1, urs_i=1 -> uev_o pulses, uif_o stays 0, cnt_o=0; mid-count aresetn_i low -> all outputs reset.
